// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
// Module : chip8_pkg
// Brief  : Shared constants and types for the CHIP-8 memory subsystem.
// Rev    : 1.0  initial release
// ============================================================================
package chip8_pkg;

    localparam logic [1:0] MEM_TYPE_REG = 2'd0;
    localparam logic [1:0] MEM_TYPE_RAM = 2'd1;
    localparam logic [1:0] MEM_TYPE_FB  = 2'd2;

    localparam int REQ_PROC   = 0;
    localparam int REQ_SPRITE = 1;
    localparam int REQ_LOADER = 2;

    localparam logic [11:0] REG_I_HI  = 12'd16;
    localparam logic [11:0] REG_I_LO  = 12'd17;
    localparam logic [11:0] REG_PC_HI = 12'd18;
    localparam logic [11:0] REG_PC_LO = 12'd19;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [7:0]  data;
        logic [1:0]  mtype;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/chip8_rr_picker.sv
`default_nettype none
// ============================================================================
// Module : chip8_rr_picker
// Brief  : Combinational round-robin picker: first wanter at or after i_ptr.
// Rev    : 1.0  initial release
// ============================================================================
module chip8_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_want,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_any
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    // Scan offsets from farthest to nearest so the nearest wanter is the last writer.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        o_any      = 1'b0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (i_want[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_grant_id     = w_idx;
                o_any          = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/chip8_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : chip8_mem_arbiter
// Brief  : Round-robin sharing of the fixed-latency memory backend, one slot
//          per cycle, with read data routed back to the issuing requester.
// Rev    : 1.0  initial release
// ============================================================================
module chip8_mem_arbiter
    import chip8_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [NUM_REQ-1:0]    want_in,
    input  logic [NUM_REQ-1:0]    valid_in,
    input  logic [NUM_REQ-1:0]    we_in,
    input  logic [NUM_REQ*12-1:0] addr_in,
    input  logic [NUM_REQ*8-1:0]  data_in,
    input  logic [NUM_REQ*2-1:0]  type_in,
    output logic [NUM_REQ-1:0]    ready_out,
    output logic [NUM_REQ-1:0]    rsp_valid_out,
    output logic [7:0]            rsp_data_out,
    output logic                  mem_valid_out,
    output logic                  mem_we_out,
    output logic [11:0]           mem_addr_out,
    output logic [7:0]            mem_data_out,
    output logic [1:0]            mem_type_out,
    input  logic [7:0]            mem_rdata_in,
    output logic                  error_out
);

    localparam int c_id_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] w_grant;
    logic [c_id_w-1:0]  w_grant_id;
    logic               w_any;
    logic [c_id_w-1:0]  r_ptr;
    logic [NUM_REQ-1:0] r_owner;
    mem_req_t           w_sel;
    logic               w_accept;
    logic               w_foreign;
    logic [NUM_REQ-1:0] r_pipe [READ_LATENCY];

    chip8_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (c_id_w)
    ) u_picker (
        .i_want     (want_in),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    // r_owner is last cycle's grant, i.e. who owns the slot happening now.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ready_out <= '0;
            r_owner   <= '0;
            r_ptr     <= '0;
        end else begin
            ready_out <= w_grant;
            r_owner   <= ready_out;
            if (w_any) begin
                r_ptr <= (w_grant_id == c_id_w'(NUM_REQ - 1)) ? '0 : w_grant_id + c_id_w'(1);
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner[i]) begin
                w_sel.we    = we_in[i];
                w_sel.addr  = addr_in[i*12 +: 12];
                w_sel.data  = data_in[i*8 +: 8];
                w_sel.mtype = type_in[i*2 +: 2];
            end
        end
    end

    assign w_accept  = |(valid_in & r_owner);
    assign w_foreign = |(valid_in & ~r_owner);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_valid_out <= 1'b0;
            mem_we_out    <= 1'b0;
            mem_addr_out  <= '0;
            mem_data_out  <= '0;
            mem_type_out  <= '0;
            error_out     <= 1'b0;
        end else begin
            mem_valid_out <= w_accept;
            mem_we_out    <= w_accept & w_sel.we;
            if (w_accept) begin
                mem_addr_out <= w_sel.addr;
                mem_data_out <= w_sel.data;
                mem_type_out <= w_sel.mtype;
            end
            if (w_foreign) begin
                error_out <= 1'b1;
            end
        end
    end

    // One-hot owner of each outstanding read travels alongside the backend latency.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_pipe[k] <= '0;
            end
            rsp_valid_out <= '0;
            rsp_data_out  <= '0;
        end else begin
            r_pipe[0] <= (w_accept && !w_sel.we) ? r_owner : '0;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
            rsp_valid_out <= r_pipe[READ_LATENCY-1];
            if (|r_pipe[READ_LATENCY-1]) begin
                rsp_data_out <= mem_rdata_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chip8_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_chip8_mem_arbiter
// Brief  : Randomised and directed bench for chip8_mem_arbiter with a
//          timeline-based reference model and a behavioural backend memory.
// Rev    : 1.0  initial release
// ============================================================================
module tb_chip8_mem_arbiter;
    import chip8_pkg::*;

    localparam int N = 3;
    localparam int L = 2;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic [N-1:0]    want_in = '0, valid_in = '0, we_in = '0;
    logic [N*12-1:0] addr_in = '0;
    logic [N*8-1:0]  data_in = '0;
    logic [N*2-1:0]  type_in = '0;
    logic [7:0]      mem_rdata_in = '0;
    logic [N-1:0]    ready_out, rsp_valid_out;
    logic [7:0]      rsp_data_out, mem_data_out;
    logic            mem_valid_out, mem_we_out, error_out;
    logic [11:0]     mem_addr_out;
    logic [1:0]      mem_type_out;

    chip8_mem_arbiter #(.NUM_REQ(N), .READ_LATENCY(L)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .want_in       (want_in),
        .valid_in      (valid_in),
        .we_in         (we_in),
        .addr_in       (addr_in),
        .data_in       (data_in),
        .type_in       (type_in),
        .ready_out     (ready_out),
        .rsp_valid_out (rsp_valid_out),
        .rsp_data_out  (rsp_data_out),
        .mem_valid_out (mem_valid_out),
        .mem_we_out    (mem_we_out),
        .mem_addr_out  (mem_addr_out),
        .mem_data_out  (mem_data_out),
        .mem_type_out  (mem_type_out),
        .mem_rdata_in  (mem_rdata_in),
        .error_out     (error_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: expectations are filed against the absolute cycle they must appear in.
    logic [7:0]   ref_mem [16384];
    logic [7:0]   bk_mem  [16384];
    logic [N-1:0] m_ready, m_owner;
    int           m_ptr;
    logic         m_err;
    logic         e_mv [16];
    logic         e_mwe [16];
    logic [11:0]  e_ma [16];
    logic [7:0]   e_md [16];
    logic [1:0]   e_mt [16];
    logic [N-1:0] e_rv [16];
    logic [7:0]   e_rd [16];
    logic         bk_v [16];
    logic [7:0]   bk_d [16];

    logic [N-1:0]    sv, swe;
    logic [N*12-1:0] sa;
    logic [N*8-1:0]  sd;
    logic [N*2-1:0]  st;

    task automatic model_reset();
        m_ready = '0; m_owner = '0; m_ptr = 0; m_err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e_mv[i] = 1'b0; e_rv[i] = '0; bk_v[i] = 1'b0;
        end
    endtask

    task automatic clr_req();
        sv = '0; swe = '0; sa = '0; sd = '0; st = '0;
    endtask

    task automatic put_req(input int j, input logic w, input logic [11:0] a,
                           input logic [7:0] d, input logic [1:0] t);
        sv[j] = 1'b1; swe[j] = w; sa[j*12 +: 12] = a; sd[j*8 +: 8] = d; st[j*2 +: 2] = t;
    endtask

    task automatic step(input logic [N-1:0] w, input logic [N-1:0] v, input logic [N-1:0] we,
                        input logic [N*12-1:0] a, input logic [N*8-1:0] d, input logic [N*2-1:0] t);
        int s;
        logic [N-1:0] nr;
        s = cyc % 16;
        chk("ready", 32'(ready_out), 32'(m_ready));
        chk("error", 32'(error_out), 32'(m_err));
        chk("mem_valid", 32'(mem_valid_out), 32'(e_mv[s]));
        if (e_mv[s]) begin
            chk("mem_we", 32'(mem_we_out), 32'(e_mwe[s]));
            chk("mem_addr", 32'(mem_addr_out), 32'(e_ma[s]));
            chk("mem_type", 32'(mem_type_out), 32'(e_mt[s]));
            if (e_mwe[s]) chk("mem_data", 32'(mem_data_out), 32'(e_md[s]));
        end
        chk("rsp_valid", 32'(rsp_valid_out), 32'(e_rv[s]));
        if (e_rv[s] != '0) chk("rsp_data", 32'(rsp_data_out), 32'(e_rd[s]));
        e_mv[s] = 1'b0;
        e_rv[s] = '0;
        // Behavioural backend: writes land at once, reads are sampled L edges after the request.
        if (mem_valid_out) begin
            if (mem_we_out) bk_mem[{mem_type_out, mem_addr_out}] = mem_data_out;
            else begin
                bk_v[(cyc + L - 1) % 16] = 1'b1;
                bk_d[(cyc + L - 1) % 16] = bk_mem[{mem_type_out, mem_addr_out}];
            end
        end
        mem_rdata_in = bk_v[s] ? bk_d[s] : 8'($urandom);
        bk_v[s] = 1'b0;
        want_in = w; valid_in = v; we_in = we; addr_in = a; data_in = d; type_in = t;
        nr = '0;
        for (int k = 0; k < N; k++) begin
            int id;
            id = (m_ptr + k) % N;
            if (nr == '0 && w[id]) begin
                nr[id] = 1'b1;
                m_ptr = (id + 1) % N;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (v[j]) begin
                if (m_owner[j]) begin
                    int s1, s2;
                    logic [13:0] idx;
                    s1 = (cyc + 1) % 16;
                    s2 = (cyc + L + 1) % 16;
                    idx = {t[j*2 +: 2], a[j*12 +: 12]};
                    e_mv[s1] = 1'b1; e_mwe[s1] = we[j]; e_ma[s1] = a[j*12 +: 12];
                    e_md[s1] = d[j*8 +: 8]; e_mt[s1] = t[j*2 +: 2];
                    if (we[j]) ref_mem[idx] = d[j*8 +: 8];
                    else begin
                        e_rv[s2] = e_rv[s2] | (N'(1) << j);
                        e_rd[s2] = ref_mem[idx];
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        m_owner = m_ready;
        m_ready = nr;
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic idle(input int n);
        clr_req();
        for (int i = 0; i < n; i++) step('0, sv, swe, sa, sd, st);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        want_in = '0; valid_in = '0; we_in = '0; addr_in = '0; data_in = '0; type_in = '0;
        #1;
        chk("rst_ready", 32'(ready_out), 32'h0);
        chk("rst_mem_valid", 32'(mem_valid_out), 32'h0);
        chk("rst_mem_bus", {3'b0, mem_we_out, mem_addr_out, mem_data_out, 6'b0, mem_type_out}, 32'h0);
        chk("rst_rsp", {21'b0, rsp_valid_out, rsp_data_out}, 32'h0);
        chk("rst_error", 32'(error_out), 32'h0);
        model_reset();
        @(negedge clk_in); cyc++;
        @(negedge clk_in); cyc++;
        rst_in = 1'b0;
    endtask

    task automatic rand_step(input bit allow_foreign);
        logic [N-1:0] w, v, we;
        logic [N*12-1:0] a;
        logic [N*8-1:0] d;
        logic [N*2-1:0] t;
        w = N'($urandom);
        we = N'($urandom);
        v = '0;
        if (m_owner != '0 && $urandom_range(0, 3) != 0) v = m_owner;
        if (allow_foreign && $urandom_range(0, 15) == 0) v[$urandom_range(0, N-1)] = 1'b1;
        for (int j = 0; j < N; j++) begin
            a[j*12 +: 12] = 12'($urandom_range(0, 15)) | 12'h200;
            d[j*8 +: 8]   = 8'($urandom);
            t[j*2 +: 2]   = 2'($urandom_range(0, 2));
        end
        step(w, v, we, a, d, t);
    endtask

    logic [N-1:0] seq [6];

    initial begin
        for (int i = 0; i < 16384; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            ref_mem[i] = b;
            bk_mem[i] = b;
        end
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
        seq[3] = 3'b001; seq[4] = 3'b010; seq[5] = 3'b100;
        model_reset();
        @(negedge clk_in);
        do_reset();

        // Single requester read of a register.
        ref_mem[{MEM_TYPE_REG, 12'h012}] = 8'h2A; bk_mem[{MEM_TYPE_REG, 12'h012}] = 8'h2A;
        clr_req();
        step(3'b001, sv, swe, sa, sd, st);
        step(3'b000, sv, swe, sa, sd, st);
        put_req(REQ_PROC, 1'b0, 12'h012, 8'h00, MEM_TYPE_REG);
        step(3'b000, sv, swe, sa, sd, st);
        idle(5);

        // Full contention: strict rotation from id 0.
        do_reset();
        clr_req();
        for (int k = 0; k < 6; k++) begin
            step(3'b111, sv, swe, sa, sd, st);
            chk("contention_seq", 32'(ready_out), 32'(seq[k]));
        end
        idle(3);

        // Interleaved reads from processor and sprite in consecutive slots.
        do_reset();
        ref_mem[{MEM_TYPE_RAM, 12'h200}] = 8'hA2; bk_mem[{MEM_TYPE_RAM, 12'h200}] = 8'hA2;
        ref_mem[{MEM_TYPE_RAM, 12'h300}] = 8'h00; bk_mem[{MEM_TYPE_RAM, 12'h300}] = 8'h00;
        clr_req();
        step(3'b011, sv, swe, sa, sd, st);
        step(3'b011, sv, swe, sa, sd, st);
        put_req(REQ_PROC, 1'b0, 12'h200, 8'h00, MEM_TYPE_RAM);
        step(3'b000, sv, swe, sa, sd, st);
        clr_req();
        put_req(REQ_SPRITE, 1'b0, 12'h300, 8'h00, MEM_TYPE_RAM);
        step(3'b000, sv, swe, sa, sd, st);
        idle(5);

        // Read-after-write across requesters.
        do_reset();
        clr_req();
        step(3'b100, sv, swe, sa, sd, st);
        step(3'b001, sv, swe, sa, sd, st);
        put_req(REQ_LOADER, 1'b1, 12'h200, 8'h55, MEM_TYPE_RAM);
        step(3'b000, sv, swe, sa, sd, st);
        clr_req();
        put_req(REQ_PROC, 1'b0, 12'h200, 8'h00, MEM_TYPE_RAM);
        step(3'b000, sv, swe, sa, sd, st);
        idle(5);

        // Random traffic, well-behaved requesters.
        do_reset();
        for (int i = 0; i < 300; i++) rand_step(1'b0);
        idle(5);

        // Protocol error: sprite drives valid in the processor's slot.
        do_reset();
        clr_req();
        step(3'b001, sv, swe, sa, sd, st);
        step(3'b000, sv, swe, sa, sd, st);
        put_req(REQ_SPRITE, 1'b1, 12'h123, 8'hEE, MEM_TYPE_RAM);
        step(3'b000, sv, swe, sa, sd, st);
        idle(4);
        chk("error_sticky", 32'(error_out), 32'h1);
        for (int i = 0; i < 100; i++) rand_step(1'b1);
        idle(5);

        // Reset one cycle after a read reaches the backend.
        do_reset();
        clr_req();
        step(3'b001, sv, swe, sa, sd, st);
        step(3'b000, sv, swe, sa, sd, st);
        put_req(REQ_PROC, 1'b0, 12'h040, 8'h00, MEM_TYPE_RAM);
        step(3'b000, sv, swe, sa, sd, st);
        clr_req();
        step(3'b000, sv, swe, sa, sd, st);
        do_reset();
        step(3'b111, sv, swe, sa, sd, st);
        chk("resume_from_0", 32'(ready_out), 32'h1);
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
